// File: rtl/or_share_arbiter.sv
// ---------------------------------------------------------------------------
// or_share_arbiter
//
// Round-robin arbiter that shares one basic_or datapath among NUM_REQ
// requesters. Each cycle at most one eligible requester is granted; its
// operand pair is routed through the shared OR unit and the result is
// registered together with the requester index.
//
// Ports:
//   clk        rising-edge system clock
//   rst_n      asynchronous active-low reset
//   req        per-requester request, held until the matching gnt bit is seen
//   a_bus      operand a of requester i on bits [i*WIDTH +: WIDTH]
//   b_bus      operand b of requester i, same packing
//   gnt        one-hot registered grant, high for one cycle per grant
//   out_valid  result valid, high in the same cycle as gnt
//   out_id     index of the requester owning the current result
//   out        registered result a|b of the granted requester
// ---------------------------------------------------------------------------

// Shared combinational OR datapath.
module basic_or #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a | b;

endmodule

module or_share_arbiter #(
  parameter  int WIDTH   = 4,
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] a_bus,
  input  logic [NUM_REQ*WIDTH-1:0] b_bus,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     out_valid,
  output logic [ID_W-1:0]          out_id,
  output logic [WIDTH-1:0]         out
);

  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               out_valid_q, out_valid_d;
  logic [ID_W-1:0]    out_id_q, out_id_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;

  logic [NUM_REQ-1:0] eligible_s;
  logic               found_s;
  logic [ID_W-1:0]    sel_s;
  logic [WIDTH-1:0]   a_sel_s;
  logic [WIDTH-1:0]   b_sel_s;
  logic [WIDTH-1:0]   or_y_s;

  // A requester granted last cycle is masked so a still-high req is not
  // granted twice for the same transaction.
  assign eligible_s = req & ~gnt_q;

  // Rotating priority search: start at ptr, wrap modulo NUM_REQ, first hit wins.
  always_comb begin
    found_s = 1'b0;
    sel_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found_s && eligible_s[idx]) begin
        found_s = 1'b1;
        sel_s   = ID_W'(idx);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Route the winner's operands to the shared OR unit.
  assign a_sel_s = a_bus[int'(sel_s)*WIDTH +: WIDTH];
  assign b_sel_s = b_bus[int'(sel_s)*WIDTH +: WIDTH];

  basic_or #(.WIDTH(WIDTH)) u_basic_or (
    .a (a_sel_s),
    .b (b_sel_s),
    .y (or_y_s)
  );

  // Next-state for grant, result and pointer; without a winner the result
  // and its tag hold while valid/grant drop.
  always_comb begin
    gnt_d       = '0;
    out_valid_d = 1'b0;
    out_id_d    = out_id_q;
    out_d       = out_q;
    ptr_d       = ptr_q;
    if (found_s) begin
      gnt_d       = NUM_REQ'(1) << sel_s;
      out_valid_d = 1'b1;
      out_id_d    = sel_s;
      out_d       = or_y_s;
      if (sel_s == ID_W'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = sel_s + ID_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State and output registers; reset drops anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_q       <= '0;
      ptr_q       <= '0;
    end else begin
      gnt_q       <= gnt_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_q       <= out_d;
      ptr_q       <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out       = out_q;

endmodule

// File: doc/or_share_arbiter.md
Name: or_share_arbiter

Overview:
Round-robin arbiter and sequencer that shares one basic_or datapath instance among NUM_REQ requesters on the Mojo board. Each requester presents an operand pair with a request. The block grants one requester per cycle, captures its operands, drives them through the shared basic_or #(.WIDTH(WIDTH)), and returns a registered result tagged with the requester index. It sits between the requester logic and the single OR unit, replacing per-requester OR instances.

Parameters:
WIDTH, 4, operand/result width passed to the internal basic_or instance
NUM_REQ, 4, number of requesters; legal range 2..8
ID_W, $clog2(NUM_REQ), width of the requester index (localparam, not overridable)

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester request; bit i held high until gnt[i] is seen
a_bus  input  NUM_REQ*WIDTH  operand a of requester i on bits [i*WIDTH +: WIDTH]
b_bus  input  NUM_REQ*WIDTH  operand b of requester i, same packing
gnt  output  NUM_REQ  one-hot registered grant, high for exactly one cycle
out_valid  output  1  result valid, high for exactly one cycle
out_id  output  ID_W  index of the requester that owns the current result
out  output  WIDTH  registered result a|b from the granted requester

Behaviour:
- Reset (rst_n low, asynchronous): gnt=0, out_valid=0, out_id=0, out=0, round-robin pointer=0 (requester 0 highest priority). Any grant or result in flight is dropped, and no out_valid is produced for it after release.
- Eligibility: eligible[i] = req[i] & ~gnt[i]. A requester granted last cycle is masked for one cycle, so a still-high req is not double-granted.
- Arbitration (combinational): search eligible from index ptr upward, wrapping modulo NUM_REQ. The first set bit wins as sel. None set -> no grant.
- Edge with a winner sel:
  - gnt <= one-hot(sel); all other gnt bits 0.
  - Operands of sel are routed to the internal basic_or.
  - out <= a_sel | b_sel; out_id <= sel; out_valid <= 1.
  - ptr <= (sel+1) mod NUM_REQ.
- Edge with no winner: gnt <= 0; out_valid <= 0; out and out_id hold their last values; ptr holds.
- Latency: req sampled high at edge N -> gnt and out_valid high in cycle N..N+1 (the same cycle), with the result for that requester. Operands must be stable at edge N only.
- Throughput: one result per cycle when 2 or more requesters are continuously eligible. A single continuously requesting requester is granted every other cycle because of the masking rule.
- Requester protocol: drop req, or present new operands, in the cycle gnt[i] is high. A req still high after the gnt cycle is treated as a new request.
- Fairness: any continuously asserted req is granted within NUM_REQ grant cycles.
- req deasserted before being granted: withdrawn; no grant is issued, no error.
- No internal state machine beyond ptr and the output registers. Implicit states are IDLE (gnt=0) and SERVE (one gnt bit set).

Test Plan:
1. Reset: drive rst_n low mid-stream while req=4'b1111 -> all outputs read 0 immediately (asynchronously, not waiting for a clk edge). First grant after release goes to requester 0.
2. Single request: req=4'b0100, a2=4'b1101, b2=4'b0101 -> next cycle gnt=4'b0100, out_valid=1, out_id=2, out=4'b1101. Req held high -> idle cycle, then re-grant.
3. Round-robin: req=4'b1111 held, operands a_i=4'b1100 and b_i={4'b0000, 4'b1110, 4'b0011, 4'b1000} -> grants 0,1,2,3,0 on consecutive cycles; out=1100,1110,1111,1100,1100.
4. Wrap and pointer: grant requester 3, then req=4'b1001 -> requester 0 is granted before 3 again; ptr wraps 3->0.
5. Idle hold: after a grant with out=4'b1110, drop all req -> gnt=0 and out_valid=0, while out=4'b1110 and out_id hold.
6. Withdraw and simultaneous: req=4'b0011 with ptr=1 -> requester 1 granted first. Requester 0 drops req before its turn -> no gnt[0] is ever issued.
